// File: rtl/harness_run_sequencer_if.sv
// Run-sequencer bus: run limits and requester reports in, harness reset, dump window and verdict out.
interface harness_run_sequencer_if #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 64
);
  logic [CNT_W-1:0] max_cycles;
  logic [CNT_W-1:0] dump_start;
  logic [N_SRC-1:0] src_mask;
  logic [N_SRC-1:0] src_done;
  logic [N_SRC-1:0] src_fail;
  logic             harness_resetn;
  logic             dump_en;
  logic [CNT_W-1:0] cycle_count;
  logic             finish;
  logic             failed;
  logic [1:0]       reason;
  logic [N_SRC-1:0] fail_vec;

  modport master (
    output max_cycles, dump_start, src_mask, src_done, src_fail,
    input  harness_resetn, dump_en, cycle_count, finish, failed, reason, fail_vec
  );

  modport slave (
    input  max_cycles, dump_start, src_mask, src_done, src_fail,
    output harness_resetn, dump_en, cycle_count, finish, failed, reason, fail_vec
  );
endinterface

// File: rtl/harness_run_sequencer.sv
// Harness run controller: reset hold, run-cycle watchdog, dump window and sticky pass/fail verdict.
// Optional post-success drain window: define HARNESS_RUN_SEQ_DRAIN_EN.
module harness_run_sequencer #(
  parameter int N_SRC        = 4,
  parameter int RESET_HOLD   = 16,
  parameter int CNT_W        = 64,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  harness_run_sequencer_if.slave bus
);

  localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [1:0] RSN_NONE    = 2'd0;
  localparam logic [1:0] RSN_SRC     = 2'd1;
  localparam logic [1:0] RSN_TIMEOUT = 2'd2;
  localparam logic [1:0] RSN_EMPTY   = 2'd3;

  if (RESET_HOLD < 1 || DRAIN_CYCLES < 1) begin : g_param_check
    $error("harness_run_sequencer: RESET_HOLD and DRAIN_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3
`ifdef HARNESS_RUN_SEQ_DRAIN_EN
    , ST_DRAIN = 3'd4
`endif
  } state_t;

  state_t            state_r, state_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0]  cycle_count_r, cycle_count_s;
  logic [N_SRC-1:0]  done_seen_r, live_fail_s, fail_vec_r, fail_vec_s;
  logic [1:0]        fail_reason_s, reason_r, reason_s;
  logic              mask_empty_s, fail_hit_s, timeout_s, all_done_s, advance_s;
  logic              harness_resetn_r, harness_resetn_s, dump_en_r, dump_en_s;
  logic              finish_r, finish_s, failed_r, failed_s;

  assign live_fail_s  = bus.src_fail & bus.src_mask;
  assign mask_empty_s = (bus.src_mask == {N_SRC{1'b0}});
  assign fail_hit_s   = |live_fail_s;
  assign timeout_s    = (bus.max_cycles != CNT_ZERO) && (cycle_count_r >= bus.max_cycles);
  // done_seen only holds past cycles, so this cycle's pulses are OR-ed in live.
  assign all_done_s   = !mask_empty_s &&
                        (((done_seen_r | bus.src_done) & bus.src_mask) == bus.src_mask);

`ifdef HARNESS_RUN_SEQ_DRAIN_EN
  localparam int               DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
  logic [DRAIN_W-1:0] drain_cnt_r;

  // Drain length counter, restarted on every DRAIN entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      drain_cnt_r <= {DRAIN_W{1'b0}};
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
    end else begin
      drain_cnt_r <= {DRAIN_W{1'b0}};
    end
  end

  assign advance_s = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
                     ((state_s == ST_RUN) || (state_s == ST_DRAIN));
`else
  assign advance_s = (state_r == ST_RUN) && (state_s == ST_RUN);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; priority is empty mask, source fail, timeout, done.
  always_comb begin
    state_s       = state_r;
    fail_reason_s = RSN_NONE;
    case (state_r)
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) state_s = ST_RUN;
        else                         state_s = ST_HOLD;
      end
      ST_RUN: begin
        if (mask_empty_s) begin
          state_s       = ST_FAIL;
          fail_reason_s = RSN_EMPTY;
        end else if (fail_hit_s) begin
          state_s       = ST_FAIL;
          fail_reason_s = RSN_SRC;
        end else if (timeout_s) begin
          state_s       = ST_FAIL;
          fail_reason_s = RSN_TIMEOUT;
        end else if (all_done_s) begin
`ifdef HARNESS_RUN_SEQ_DRAIN_EN
          state_s = ST_DRAIN;
`else
          state_s = ST_PASS;
`endif
        end else begin
          state_s = ST_RUN;
        end
      end
`ifdef HARNESS_RUN_SEQ_DRAIN_EN
      ST_DRAIN: begin
        if (fail_hit_s) begin
          state_s       = ST_FAIL;
          fail_reason_s = RSN_SRC;
        end else if (timeout_s) begin
          state_s       = ST_FAIL;
          fail_reason_s = RSN_TIMEOUT;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          state_s = ST_PASS;
        end else begin
          state_s = ST_DRAIN;
        end
      end
`endif
      ST_PASS: state_s = ST_PASS;
      ST_FAIL: state_s = ST_FAIL;
      default: state_s = ST_HOLD;
    endcase
  end

  // Cycle counter advances only while the run continues, so a terminal entry freezes it.
  always_comb begin
    if (advance_s && (cycle_count_r != CNT_MAX)) cycle_count_s = cycle_count_r + CNT_ONE;
    else                                         cycle_count_s = cycle_count_r;
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    harness_resetn_s = (state_s != ST_HOLD);
    finish_s         = (state_s == ST_PASS) || (state_s == ST_FAIL);
    failed_s         = (state_s == ST_FAIL);
    dump_en_s        = 1'b0;
    if ((state_s == ST_FAIL) && (state_r != ST_FAIL)) begin
      reason_s   = fail_reason_s;
      fail_vec_s = live_fail_s;
    end else begin
      reason_s   = reason_r;
      fail_vec_s = fail_vec_r;
    end
    case (state_s)
      ST_HOLD: dump_en_s = (bus.dump_start == CNT_ZERO);
      ST_RUN:  dump_en_s = (bus.dump_start == CNT_ZERO) || (cycle_count_s >= bus.dump_start);
`ifdef HARNESS_RUN_SEQ_DRAIN_EN
      ST_DRAIN: dump_en_s = (bus.dump_start == CNT_ZERO) || (cycle_count_s >= bus.dump_start);
`endif
      default: dump_en_s = 1'b0;
    endcase
  end

  // Hold counter, run counter and sticky done accumulation.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_cnt_r    <= {HOLD_W{1'b0}};
      cycle_count_r <= CNT_ZERO;
      done_seen_r   <= {N_SRC{1'b0}};
    end else begin
      if ((state_r == ST_HOLD) && (state_s == ST_HOLD)) hold_cnt_r <= hold_cnt_r + HOLD_ONE;
      else                                               hold_cnt_r <= hold_cnt_r;
      cycle_count_r <= cycle_count_s;
      if (state_r == ST_RUN) done_seen_r <= done_seen_r | (bus.src_done & bus.src_mask);
      else                   done_seen_r <= done_seen_r;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      harness_resetn_r <= 1'b0;
      dump_en_r        <= 1'b0;
      finish_r         <= 1'b0;
      failed_r         <= 1'b0;
      reason_r         <= RSN_NONE;
      fail_vec_r       <= {N_SRC{1'b0}};
    end else begin
      harness_resetn_r <= harness_resetn_s;
      dump_en_r        <= dump_en_s;
      finish_r         <= finish_s;
      failed_r         <= failed_s;
      reason_r         <= reason_s;
      fail_vec_r       <= fail_vec_s;
    end
  end

  assign bus.harness_resetn = harness_resetn_r;
  assign bus.dump_en        = dump_en_r;
  assign bus.cycle_count    = cycle_count_r;
  assign bus.finish         = finish_r;
  assign bus.failed         = failed_r;
  assign bus.reason         = reason_r;
  assign bus.fail_vec       = fail_vec_r;

endmodule
